piso_serializer: RTL and testbench

- Parallel-in, serial-out converter that feeds the team's SISO shift-register chain one bit per clock.
- Accepts N-bit words over a valid/ready load handshake.
- A one-word holding buffer lets consecutive words stream gaplessly.
- The serial output drives the downstream shift register's serial data input directly.

---
 rtl/piso_serializer_pkg.sv | 15 +
 rtl/piso_hold_buf.sv | 40 ++++
 rtl/piso_serializer.sv | 98 +++++++++
 tb/tb_piso_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam bit LSB_FIRST_DEFAULT = 1'b1;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry holding register; a load in the same cycle as an unload refills it.
module piso_hold_buf #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_in,
    input  logic         unload_in,
    input  logic [N-1:0] data_in,
    output logic [N-1:0] data_out,
    output logic         full_out
);

    logic [N-1:0] hold_q, hold_d;
    logic         full_q, full_d;

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (unload_in) full_d = 1'b0;
        if (load_in) begin
            hold_d = data_in;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
        end
    end

    assign data_out = hold_q;
    assign full_out = full_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out converter with a one-word holding buffer for gapless streaming.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int N         = 4,
    parameter bit LSB_FIRST = LSB_FIRST_DEFAULT
) (
    input  logic         clk,
    input  logic         reset_ah_in,
    input  logic [N-1:0] data_in,
    input  logic         load_valid_in,
    output logic         load_ready_out,
    input  logic         shift_en_in,
    output logic         q_out,
    output logic         q_valid_out,
    output logic         first_bit_out,
    output logic         word_done_out
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e          state_q, state_d;
    logic [N-1:0]    sh_q, sh_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            hold_full, hold_load, hold_unload;
    logic [N-1:0]    hold_data;
    logic            accept, last_edge;

    assign load_ready_out = ~hold_full;
    assign accept         = load_valid_in & ~hold_full;
    assign last_edge      = (state_q == ST_SHIFT) & shift_en_in & (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_load   = 1'b0;
        hold_unload = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sh_d    = data_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A word arriving on a last-bit edge with an empty hold bypasses it.
                hold_load = accept & ~(last_edge & ~hold_full);
                if (shift_en_in && cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                    sh_d  = LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
                end else if (last_edge) begin
                    cnt_d = '0;
                    if (hold_full) begin
                        sh_d        = hold_data;
                        hold_unload = 1'b1;
                    end else if (accept) begin
                        sh_d = data_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
        end
    end

    piso_hold_buf #(.N(N)) u_hold (
        .clk       (clk),
        .rst       (reset_ah_in),
        .load_in   (hold_load),
        .unload_in (hold_unload),
        .data_in   (data_in),
        .data_out  (hold_data),
        .full_out  (hold_full)
    );

    assign q_valid_out   = (state_q == ST_SHIFT);
    assign q_out         = q_valid_out & (LSB_FIRST ? sh_q[0] : sh_q[N-1]);
    assign first_bit_out = q_valid_out & (cnt_q == '0);
    assign word_done_out = last_edge;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: LSB-first main instance plus an MSB-first instance.
module tb_piso_serializer;

    localparam int N = 4;

    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] data_in;
    logic         load_valid, load_ready, shift_en;
    logic         q_out, q_valid, first_bit, word_done;

    logic [N-1:0] data_m;
    logic         valid_m, ready_m;
    logic         q_m, q_valid_m, first_m, done_m;

    logic [3:0]   siso;

    exp_t sb[$];
    int   n_chk = 0, n_pass = 0;
    int   run = 0, max_run = 0, vcycles = 0;

    always #5 clk = ~clk;

    piso_serializer #(.N(N), .LSB_FIRST(1'b1)) dut (
        .clk            (clk),
        .reset_ah_in    (rst),
        .data_in        (data_in),
        .load_valid_in  (load_valid),
        .load_ready_out (load_ready),
        .shift_en_in    (shift_en),
        .q_out          (q_out),
        .q_valid_out    (q_valid),
        .first_bit_out  (first_bit),
        .word_done_out  (word_done)
    );

    piso_serializer #(.N(N), .LSB_FIRST(1'b0)) dut_msb (
        .clk            (clk),
        .reset_ah_in    (rst),
        .data_in        (data_m),
        .load_valid_in  (valid_m),
        .load_ready_out (ready_m),
        .shift_en_in    (1'b1),
        .q_out          (q_m),
        .q_valid_out    (q_valid_m),
        .first_bit_out  (first_m),
        .word_done_out  (done_m)
    );

    // Downstream 4-stage SISO fed directly from the serial output.
    always @(posedge clk or posedge rst) begin
        if (rst) siso <= '0;
        else     siso <= {siso[2:0], q_out};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_word(input logic [N-1:0] w);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.b     = w[i];
            e.first = (i == 0);
            e.last  = (i == N - 1);
            sb.push_back(e);
        end
    endtask

    // Returns one time unit after the accepting edge.
    task automatic send(input logic [N-1:0] w);
        bit done;
        done       = 1'b0;
        data_in    = w;
        load_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (load_ready) begin
                push_word(w);
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        load_valid = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) done = 1'b1;
        end
        chk("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q_valid) begin
            run++;
            vcycles++;
            if (run > max_run) max_run = run;
            if (sb.size() == 0) begin
                chk("unexpected_bit", 1, 0);
            end else begin
                chk("q_out", q_out, sb[0].b);
                chk("first_bit", first_bit, sb[0].first);
                chk("word_done", word_done, sb[0].last & shift_en);
                if (shift_en) void'(sb.pop_front());
            end
        end else begin
            run = 0;
            chk("idle_q_out", q_out, 0);
            chk("idle_word_done", word_done, 0);
        end
    end

    initial begin
        logic [3:0] wm;
        rst        = 1'b1;
        data_in    = '0;
        load_valid = 1'b0;
        shift_en   = 1'b1;
        data_m     = '0;
        valid_m    = 1'b0;
        #12;
        chk("rst_ready", load_ready, 1);
        chk("rst_q_valid", q_valid, 0);
        chk("rst_q_out", q_out, 0);
        chk("rst_first", first_bit, 0);
        chk("rst_msb_ready", ready_m, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word, free running.
        max_run = 0; vcycles = 0;
        send(4'b1011);
        drain();
        chk("t1_run", max_run, 4);
        chk("t1_vcycles", vcycles, 4);

        // Back-to-back words through the holding buffer.
        max_run = 0; vcycles = 0;
        send(4'hA);
        send(4'h5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_ready_low", load_ready, 0);
        end
        @(negedge clk);
        chk("t2_ready_back", load_ready, 1);
        drain();
        chk("t2_run", max_run, 8);

        // Stall on bit 1 for two cycles.
        max_run = 0; vcycles = 0;
        send(4'b0110);
        @(posedge clk); #1;
        shift_en = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        shift_en = 1'b1;
        drain();
        chk("t3_vcycles", vcycles, 6);

        // Reset mid-word with a held word pending.
        send(4'hF);
        send(4'h3);
        @(posedge clk); #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_q_valid", q_valid, 0);
        chk("mid_rst_q_out", q_out, 0);
        chk("mid_rst_ready", load_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_q_valid", q_valid, 0);
        @(posedge clk); #1;
        max_run = 0; vcycles = 0;
        send(4'h9);
        drain();
        chk("t4_vcycles", vcycles, 4);

        // Chained SISO reproduces the serial stream four cycles later.
        send(4'hC);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k >= 5) chk("siso_out", siso[3], (k >= 7) ? 1 : 0);
        end
        drain();

        // MSB-first instance.
        wm = 4'b1000;
        @(negedge clk);
        chk("msb_ready", ready_m, 1);
        data_m  = wm;
        valid_m = 1'b1;
        @(posedge clk); #1;
        valid_m = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("msb_valid", q_valid_m, 1);
            chk("msb_q", q_m, wm[3-k]);
            chk("msb_done", done_m, (k == 3) ? 1 : 0);
        end
        @(negedge clk);
        chk("msb_idle", q_valid_m, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
